// File: rtl/axis_traffic_checker.sv
// AXI-Stream traffic sink: accepts flits (optionally with LFSR backpressure) and
// checks destination, source, sequence number and packet length of each beat.
module axis_traffic_checker #(
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned SEQ_WIDTH   = 16,
  parameter int unsigned IDX_WIDTH   = 8,
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned MY_ID       = 0,
  parameter int unsigned PKT_LEN     = 4,
  parameter int unsigned STALL_MODE  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sink_en,
  input  logic                   err_clear,
  input  logic                   axis_tvalid,
  output logic                   axis_tready,
  input  logic [TDATA_WIDTH-1:0] axis_tdata,
  input  logic                   axis_tlast,
  input  logic [TDEST_WIDTH-1:0] axis_tdest,
  output logic [31:0]            pkt_count,
  output logic [31:0]            flit_count,
  output logic                   err_dest,
  output logic                   err_src,
  output logic                   err_seq,
  output logic                   err_len
);

  localparam int unsigned FIELD_W = SEQ_WIDTH + IDX_WIDTH + TDEST_WIDTH;
  localparam int unsigned SRC_IW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX = IDX_WIDTH'(PKT_LEN - 1);
  localparam logic [TDEST_WIDTH-1:0] MY_DEST  = TDEST_WIDTH'(MY_ID);

  // Checker state
  logic [15:0]            lfsr;
  logic [IDX_WIDTH-1:0]   bcnt;
  logic [TDEST_WIDTH-1:0] cur_src;
  logic [SEQ_WIDTH-1:0]   cur_seq;
  logic                   cur_bad;
  logic [SEQ_WIDTH-1:0]   exp_seq [NUM_SRC];

  // Combinational decode of the current beat
  logic [15:0]            lfsr_next;
  logic                   stall_next;
  logic                   accept;
  logic                   first;
  logic [SEQ_WIDTH-1:0]   seq_in;
  logic [IDX_WIDTH-1:0]   idx_in;
  logic [TDEST_WIDTH-1:0] src_in;
  logic                   src_bad;
  logic                   pkt_bad;
  logic [SRC_IW-1:0]      eff_idx;
  logic [SEQ_WIDTH-1:0]   eff_seq;
  logic [SEQ_WIDTH-1:0]   exp_first;
  logic                   new_dest;
  logic                   new_src;
  logic                   new_seq;
  logic                   new_len;

  assign seq_in = axis_tdata[SEQ_WIDTH-1:0];
  assign idx_in = axis_tdata[SEQ_WIDTH +: IDX_WIDTH];
  assign src_in = axis_tdata[SEQ_WIDTH + IDX_WIDTH +: TDEST_WIDTH];

  // Payload bits above the checked fields carry no meaning for the checker
  if (TDATA_WIDTH > FIELD_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^axis_tdata[TDATA_WIDTH-1:FIELD_W];
  end

  // Next LFSR value, backpressure decision and per-beat error detection
  always_comb begin
    lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    stall_next = 1'b0;
    if (STALL_MODE == 1) begin
      stall_next = lfsr_next[0] & lfsr_next[1];
    end

    accept    = axis_tvalid & axis_tready;
    first     = (bcnt == '0);
    src_bad   = (32'(src_in) >= NUM_SRC);
    pkt_bad   = first ? src_bad : cur_bad;
    eff_idx   = first ? src_in[SRC_IW-1:0] : cur_src[SRC_IW-1:0];
    eff_seq   = first ? seq_in : cur_seq;
    exp_first = exp_seq[src_in[SRC_IW-1:0]];

    new_dest = accept & (axis_tdest != MY_DEST);
    new_src  = accept & src_bad;
    new_seq  = 1'b0;
    if (accept && !pkt_bad) begin
      new_seq = first ? (seq_in != exp_first)
                      : ((seq_in != cur_seq) || (src_in != cur_src));
    end
    new_len = accept & ((idx_in != bcnt) ||
                        (axis_tlast && (bcnt != LAST_IDX)) ||
                        (!axis_tlast && (bcnt == LAST_IDX)));
  end

  // LFSR, registered ready and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr        <= LFSR_SEED;
      axis_tready <= 1'b0;
      err_dest    <= 1'b0;
      err_src     <= 1'b0;
      err_seq     <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      lfsr        <= lfsr_next;
      axis_tready <= sink_en & ~stall_next;
      // A fresh error beats a simultaneous clear
      err_dest    <= new_dest | (err_dest & ~err_clear);
      err_src     <= new_src  | (err_src  & ~err_clear);
      err_seq     <= new_seq  | (err_seq  & ~err_clear);
      err_len     <= new_len  | (err_len  & ~err_clear);
    end
  end

  // Packet tracking, counters and per-source expected sequence numbers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt       <= '0;
      cur_src    <= '0;
      cur_seq    <= '0;
      cur_bad    <= 1'b0;
      pkt_count  <= '0;
      flit_count <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        exp_seq[i] <= '0;
      end
    end else if (accept) begin
      flit_count <= flit_count + 32'd1;
      if (first) begin
        cur_src <= src_in;
        cur_seq <= seq_in;
        cur_bad <= src_bad;
      end
      if (axis_tlast) begin
        bcnt      <= '0;
        pkt_count <= pkt_count + 32'd1;
        // Resync to the received number so one lost packet flags only once
        if (!pkt_bad) begin
          exp_seq[eff_idx] <= eff_seq + SEQ_WIDTH'(1);
        end
      end else begin
        bcnt <= bcnt + IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_traffic_checker.sv
// Directed bench for axis_traffic_checker: vector table for packet checks plus
// hand sequences for reset-mid-packet and LFSR backpressure streaming.
module tb_axis_traffic_checker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sink_en, err_clear, tvalid, tlast;
  logic [511:0] tdata;
  logic [3:0]   tdest;
  logic         tready;
  logic [31:0]  pkt_count, flit_count;
  logic         e_dest, e_src, e_seq, e_len;

  logic         s_sink_en, s_err_clear, s_tvalid, s_tlast;
  logic [511:0] s_tdata;
  logic [3:0]   s_tdest;
  logic         s_tready;
  logic [31:0]  s_pkt, s_flit;
  logic         s_e_dest, s_e_src, s_e_seq, s_e_len;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_traffic_checker #(.MY_ID(1), .PKT_LEN(4), .STALL_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .sink_en(sink_en), .err_clear(err_clear),
    .axis_tvalid(tvalid), .axis_tready(tready), .axis_tdata(tdata),
    .axis_tlast(tlast), .axis_tdest(tdest), .pkt_count(pkt_count),
    .flit_count(flit_count), .err_dest(e_dest), .err_src(e_src),
    .err_seq(e_seq), .err_len(e_len)
  );

  axis_traffic_checker #(.MY_ID(1), .PKT_LEN(4), .STALL_MODE(1),
                         .LFSR_SEED(16'hACE1)) dut_stall (
    .clk(clk), .rst_n(rst_n), .sink_en(s_sink_en), .err_clear(s_err_clear),
    .axis_tvalid(s_tvalid), .axis_tready(s_tready), .axis_tdata(s_tdata),
    .axis_tlast(s_tlast), .axis_tdest(s_tdest), .pkt_count(s_pkt),
    .flit_count(s_flit), .err_dest(s_e_dest), .err_src(s_e_src),
    .err_seq(s_e_seq), .err_len(s_e_len)
  );

  typedef struct {
    logic        valid;
    logic        last;
    logic        clr;
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [15:0] seq;
    logic [7:0]  idx;
    logic [31:0] epkt;
    logic [31:0] eflit;
    logic [3:0]  eerr;   // {dest, src, seq, len}
  } vec_t;

  vec_t vq[$];
  int   run_pkt  = 0;
  int   run_flit = 0;

  function automatic logic [511:0] mk(input logic [3:0] s, input logic [7:0] i,
                                      input logic [15:0] q);
    logic [511:0] d;
    d = '0;
    d[15:0]    = q;
    d[23:16]   = i;
    d[27:24]   = s;
    d[511:500] = 12'hABC;
    return d;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic v, input logic l, input logic c, input int d,
                     input int s, input int q, input int i, input logic [3:0] e);
    vec_t x;
    if (v) run_flit++;
    if (v && l) run_pkt++;
    x.valid = v; x.last = l; x.clr = c;
    x.dest = 4'(d); x.src = 4'(s); x.seq = 16'(q); x.idx = 8'(i);
    x.epkt = 32'(run_pkt); x.eflit = 32'(run_flit); x.eerr = e;
    vq.push_back(x);
  endtask

  // Four-beat packet; flags are expected constant across it
  task automatic add_pkt(input int d, input int s, input int q, input logic [3:0] e);
    for (int i = 0; i < 4; i++) add(1'b1, i == 3, 1'b0, d, s, q, i, e);
  endtask

  task automatic idle(input logic c, input logic [3:0] e);
    add(1'b0, 1'b0, c, 1, 0, 0, 0, e);
  endtask

  task automatic drive(input logic v, input logic l, input int d, input int s,
                       input int q, input int i);
    tvalid = v; tlast = l; tdest = 4'(d); tdata = mk(4'(s), 8'(i), 16'(q));
  endtask

  initial begin
    logic [15:0] model;
    logic        acc, exp_rdy;
    int          g, lows, cyc;

    rst_n = 1'b0; sink_en = 1'b1; err_clear = 1'b0;
    drive(1'b0, 1'b0, 1, 0, 0, 0);
    s_sink_en = 1'b0; s_err_clear = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdest = 4'd1; s_tdata = '0;

    // Vector table
    add_pkt(1, 2, 0, 4'b0000);
    add_pkt(1, 2, 1, 4'b0000);
    add_pkt(1, 2, 2, 4'b0000);
    add_pkt(3, 2, 3, 4'b1000);
    idle(1'b0, 4'b1000);
    idle(1'b1, 4'b0000);
    idle(1'b0, 4'b0000);
    add(1'b1, 1'b0, 1'b1, 3, 2, 4, 0, 4'b1000);
    add(1'b1, 1'b0, 1'b0, 1, 2, 4, 1, 4'b1000);
    add(1'b1, 1'b0, 1'b0, 1, 2, 4, 2, 4'b1000);
    add(1'b1, 1'b1, 1'b0, 1, 2, 4, 3, 4'b1000);
    idle(1'b1, 4'b0000);
    add_pkt(1, 0, 0, 4'b0000);
    add_pkt(1, 0, 2, 4'b0010);
    idle(1'b1, 4'b0000);
    add_pkt(1, 0, 3, 4'b0000);
    add_pkt(1, 0, 4, 4'b0000);
    add(1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 4'b0000);
    add(1'b1, 1'b0, 1'b0, 1, 1, 0, 1, 4'b0000);
    add(1'b1, 1'b1, 1'b0, 1, 1, 0, 2, 4'b0001);
    idle(1'b1, 4'b0000);
    add_pkt(1, 1, 1, 4'b0000);
    add_pkt(1, 5, 7, 4'b0100);
    idle(1'b1, 4'b0000);
    add_pkt(1, 2, 5, 4'b0000);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", 32'(tready), 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_flit", flit_count, 0);
    chk("rst_err", 32'({e_dest, e_src, e_seq, e_len}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(tready), 1);

    foreach (vq[i]) begin
      drive(vq[i].valid, vq[i].last, vq[i].dest, vq[i].src, vq[i].seq, vq[i].idx);
      err_clear = vq[i].clr;
      @(negedge clk);
      chk($sformatf("v%0d_tready", i), 32'(tready), 1);
      chk($sformatf("v%0d_pkt", i), pkt_count, vq[i].epkt);
      chk($sformatf("v%0d_flit", i), flit_count, vq[i].eflit);
      chk($sformatf("v%0d_err", i), 32'({e_dest, e_src, e_seq, e_len}), 32'(vq[i].eerr));
    end
    err_clear = 1'b0;
    drive(1'b0, 1'b0, 1, 0, 0, 0);

    // Reset in the middle of a packet
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1, 2, 6, i);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tready", 32'(tready), 0);
    chk("midrst_pkt", pkt_count, 0);
    chk("midrst_flit", flit_count, 0);
    chk("midrst_err", 32'({e_dest, e_src, e_seq, e_len}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 3, 1, 2, 0, i);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1, 0, 0, 0);
    chk("post_rst_pkt", pkt_count, 1);
    chk("post_rst_flit", flit_count, 4);
    chk("post_rst_err", 32'({e_dest, e_src, e_seq, e_len}), 0);

    // LFSR backpressure streaming on the stalling instance
    rst_n = 1'b0; s_sink_en = 1'b1;
    repeat (2) @(negedge clk);
    model = 16'hACE1;
    rst_n = 1'b1;
    g = 0; lows = 0; cyc = 0;
    s_tvalid = 1'b1;
    while (g < 1000 && cyc < 5000) begin
      s_tdata = mk(4'd0, 8'(g % 4), 16'(g / 4));
      s_tlast = (g % 4) == 3;
      acc = s_tready;
      @(posedge clk);
      model = lfsr_step(model);
      @(negedge clk);
      exp_rdy = ~(model[0] & model[1]);
      chk($sformatf("stall_c%0d_tready", cyc), 32'(s_tready), 32'(exp_rdy));
      if (!exp_rdy) lows++;
      if (acc) g++;
      cyc++;
    end
    s_tvalid = 1'b0;
    chk("stall_stream_done", 32'(g), 1000);
    chk("stall_flit", s_flit, 1000);
    chk("stall_pkt", s_pkt, 250);
    chk("stall_err", 32'({s_e_dest, s_e_src, s_e_seq, s_e_len}), 0);
    chk("stall_ratio_ok", 32'((lows * 100 >= cyc * 15) && (lows * 100 <= cyc * 35)), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_traffic_checker.md
# axis_traffic_checker

Synthesizable AXI-Stream sink that terminates one user-side output port of the mesh (`axis_out_*` of one node) and self-checks the traffic produced by matching generators. It accepts flits with optional pseudo-random backpressure, verifies destination, source, sequence number and packet length, and exposes sticky error flags and packet/flit counters for on-chip or simulation status readout. It runs in the user clock domain and replaces hand-written bench sequences as the mesh's response checker.

## Interface
- `TDEST_WIDTH`, 4: width of tdest and of the embedded source-ID field.
- `TDATA_WIDTH`, 512: flit width; must be at least SEQ_WIDTH+IDX_WIDTH+TDEST_WIDTH.
- `SEQ_WIDTH`, 16: sequence-number field width.
- `IDX_WIDTH`, 8: flit-index field width.
- `NUM_SRC`, 4: number of legal sources (IDs 0..NUM_SRC-1).
- `MY_ID`, 0: this node's ID; every accepted flit must carry tdest == MY_ID.
- `PKT_LEN`, 4: flits per packet, 1..2^IDX_WIDTH.
- `STALL_MODE`, 0: 0 = no backpressure; 1 = LFSR backpressure.
- `LFSR_SEED`, 16'hACE1: nonzero LFSR reset value.
- `clk` in 1: user clock; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `sink_en` in 1: gates tready; 0 stops acceptance.
- `err_clear` in 1: single-cycle pulse that clears the sticky error flags.
- `axis_tvalid` in 1: flit valid.
- `axis_tready` out 1: flit ready.
- `axis_tdata` in TDATA_WIDTH: flit payload.
- `axis_tlast` in 1: last flit of packet.
- `axis_tdest` in TDEST_WIDTH: destination ID.
- `pkt_count` out 32: number of accepted packets (tlast beats).
- `flit_count` out 32: number of accepted beats.
- `err_dest`, `err_src`, `err_seq`, `err_len` out 1 each: sticky error flags.

## Operation
- Payload fields: seq = tdata[SEQ_WIDTH-1:0]; idx = tdata[SEQ_WIDTH+IDX_WIDTH-1:SEQ_WIDTH]; src = the next TDEST_WIDTH bits. Remaining bits are ignored.
- A beat is accepted when `axis_tvalid & axis_tready`. All checks and updates happen only on accepted beats.
- `axis_tready` = `sink_en & ~stall`.
  - With STALL_MODE=0, stall is 0.
  - With STALL_MODE=1, stall = lfsr[0] & lfsr[1], giving about 25% stall cycles.
  - The 16-bit Fibonacci LFSR uses taps 16, 14, 13, 11 and advances every cycle after reset, independent of traffic.
- State: beat counter `bcnt` (IDX_WIDTH bits, 0 = idle/first beat); first-beat latches `cur_src` and `cur_seq`; an `exp_seq[NUM_SRC]` array (SEQ_WIDTH bits each, reset 0).
- Checks on each accepted beat:
  - `err_dest`: tdest != MY_ID.
  - `err_src`: src >= NUM_SRC. The seq check and the exp_seq update are skipped for that packet.
  - `err_len`: any of idx != bcnt; tlast with bcnt != PKT_LEN-1; no tlast with bcnt == PKT_LEN-1.
  - `err_seq`, first beat (bcnt==0): seq != exp_seq[src].
  - `err_seq`, later beats: seq != cur_seq or src != cur_src.
- On tlast:
  - bcnt <= 0.
  - pkt_count++.
  - exp_seq[cur_src] <= cur_seq+1, modulo 2^SEQ_WIDTH. This resyncs to the received seq, so a single dropped or duplicated packet raises err_seq once and does not cascade.
  - For PKT_LEN=1, the first-beat values are used directly.
- Without tlast, bcnt increments and wraps at 2^IDX_WIDTH.
- Every accepted beat increments flit_count. Both counters wrap at 2^32.
- Error flags are sticky until `err_clear`. If a new error and err_clear occur in the same cycle, the new error wins (flag = 1).

## Timing
- Reset values: axis_tready 0, all counters 0, all error flags 0, bcnt 0, exp_seq all 0, LFSR = LFSR_SEED.
- axis_tready is registered and reflects sink_en with 1-cycle latency, so the first possible acceptance is 1 cycle after rst_n rises with sink_en=1.
- Counters and error flags update on the edge that accepts the beat and are visible the following cycle (1-cycle latency). There is no other pipelining, and back-to-back beats are accepted at full rate.
- tvalid without tready: no state change except the LFSR. tdata/tdest/tlast are sampled only on the accept edge.
- Reset asserted mid-packet discards the partial packet, with no error raised.
- Deasserting sink_en mid-packet is legal; checking continues on resumption.

## Test plan
- STALL_MODE=0, PKT_LEN=4, MY_ID=1: src 2 sends seq 0,1,2 (idx 0..3, tlast on idx 3) -> pkt_count=3, flit_count=12, all error flags 0, tready 1 throughout.
- Packet with tdest=3 to MY_ID=1 -> err_dest=1 the cycle after the beat; stays 1 until err_clear; clears the cycle after the pulse.
- src 0 sends seq 0 then seq 2 -> err_seq=1 once; a following seq 3 raises no new error (verify by clearing between packets); exp_seq[0]=4.
- tlast on idx 2 with PKT_LEN=4 -> err_len=1, pkt_count increments, next packet starting at idx 0 is clean.
- STALL_MODE=1, seed 16'hACE1, 1000 flits streamed with continuous tvalid -> no data loss (flit_count=1000), tready low on roughly 25% of cycles, low cycles match the reference LFSR model.
- rst_n low for 1 cycle after 2 beats of a 4-flit packet -> all outputs return to reset values; a fresh packet with seq 0 checks clean.
